// File: rtl/ps2_rx_frame_if.sv
// Receive-side result bus of the PS/2 frame receiver: byte, strobes and busy.
interface ps2_rx_frame_if;
    logic [7:0] data;
    logic       rdy;
    logic       err;
    logic       busy;

    modport master (output data, output rdy, output err, output busy);
    modport slave  (input  data, input  rdy, input  err, input  busy);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, falling-edge sample, start/parity/stop check.
// Optional clock glitch filter enabled by defining PS2_RX_FILTER_EN.
module ps2_rx_frame #(
    parameter int CLK_HZ     = 12000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_rx_frame_if.master    bus
);

    localparam int TO_MAX = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_MAX + 1);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          edge_clk, samp, clk_prev, fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic [7:0]    data_q;
    logic          rdy_q, err_q, busy_q;

    // Idle-high bus: synchronisers come out of reset at 1 so no false edge appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

`ifdef PS2_RX_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0]         flt_cnt;
    logic                  flt_clk;
    logic [FILTER_LEN-1:0] dat_dly;

    // Level flips only after FILTER_LEN consecutive disagreeing samples;
    // data rides a matching delay line so it stays aligned with the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_cnt <= '0;
            flt_clk <= 1'b1;
            dat_dly <= '1;
        end else begin
            if (clk_s2 == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_clk <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
            dat_dly[0] <= dat_s2;
            for (int i = 1; i < FILTER_LEN; i++) dat_dly[i] <= dat_dly[i-1];
        end
    end

    assign edge_clk = flt_clk;
    assign samp     = dat_dly[FILTER_LEN-1];
`else
    assign edge_clk = clk_s2;
    assign samp     = dat_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clk_prev <= 1'b1;
        else      clk_prev <= edge_clk;
    end

    assign fall = clk_prev & ~edge_clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;

            if (fall)
                to_cnt <= '0;
            else if (state != IDLE && to_cnt != TW'(TO_MAX))
                to_cnt <= to_cnt + 1'b1;

            // A stalled frame is abandoned; timeout wins over a coincident edge.
            if (state != IDLE && to_cnt == TW'(TO_MAX)) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
                to_cnt <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!samp) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {samp, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= samp;
                        state <= STOP;
                    end
                    STOP: begin
                        if (samp && (^{shift, par})) begin
                            data_q <= shift;
                            rdy_q  <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data = data_q;
    assign bus.rdy  = rdy_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised bench for ps2_rx_frame against a frame-level reference model.
module tb_ps2_rx_frame;
  localparam int CLK_HZ = 12000000;
  localparam int H      = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_frame_if bus();

  ps2_rx_frame #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(200), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0, last_err_cyc = 0;
  int rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_rdy = 0, exp_err = 0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rdy) begin
      rdy_cnt++;
      obs_q.push_back(bus.data);
    end
    if (bus.err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.rdy && bus.err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of an 11-bit frame; full frames update the model.
  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                      input int nbits = 11, input int glitch_at = -1);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (($countones(d) % 2) == 0) ^ bad_par;
    f[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_at) begin
        tick(H/2);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(H/2 - 1);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      tick(H);
      ps2_clk = 1'b1;
    end
    if (nbits == 11) begin
      if (f[10] && ($countones(f[9:1]) % 2 == 1)) begin
        exp_rdy++;
        exp_data = d;
        exp_q.push_back(d);
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic check_state(input string tag);
    tick(10);
    ps2_data = 1'b1;
    chk({tag, ".rdy_cnt"}, rdy_cnt, exp_rdy);
    chk({tag, ".err_cnt"}, err_cnt, exp_err);
    chk({tag, ".data"}, bus.data, exp_data);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".nbytes"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, ".byte"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int d;
    tick(3);
    chk("reset.data", bus.data, 8'h00);
    chk("reset.rdy", bus.rdy, 1'b0);
    chk("reset.err", bus.err, 1'b0);
    chk("reset.busy", bus.busy, 1'b0);
    rst = 1'b1;
    tick(5);

    send(8'h1C, 0, 0);
    check_state("f1c");

    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    check_state("b2b");

    send(8'h1C, 1, 0);
    check_state("badpar");

    send(8'h12, 0, 1);
    check_state("badstop");

    send(8'hA5, 0, 0, 5);
    tick(5);
    chk("to.busy_mid", bus.busy, 1'b1);
    tick(2500);
    exp_err++;
    d = last_err_cyc - fall_cyc;
    chk("to.latency_ok", (d >= 2400 && d <= 2410), 1'b1);
    check_state("timeout");
    send(8'h29, 0, 0);
    check_state("after_to");

    send(8'h77, 0, 0, 6);
    rst = 1'b0;
    exp_data = 8'h00;
    tick(5);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.data", bus.data, 8'h00);
    chk("rst.rdy_cnt", rdy_cnt, exp_rdy);
    chk("rst.err_cnt", err_cnt, exp_err);
    rst = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    send(8'h5A, 0, 0);
    check_state("after_rst");

`ifdef PS2_RX_FILTER_EN
    send(8'h3C, 0, 0, 11, 4);
    check_state("glitch");
`endif

    for (int k = 0; k < 20; k++) begin
      send(8'($urandom), ($urandom % 5) == 0, ($urandom % 5) == 0);
      check_state("rand");
    end

    chk("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 device-to-host frame receiver. It sits directly upstream of the keyboard handler, which consumes `data` and `rdy` in the clk domain. It synchronises the open-collector `ps2_clk`/`ps2_data` lines, samples each bit on a falling `ps2_clk` edge, and checks start, odd parity and stop bits. For each valid 11-bit frame it delivers one scan-code byte with a 1-cycle strobe; bad frames are flagged and discarded.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz; used to derive the timeout count.
TIMEOUT_US, 200, maximum gap between falling `ps2_clk` edges inside a frame before the frame is aborted.
FILTER_LEN, 4, number of consecutive identical synchronised `ps2_clk` samples needed to accept a level change (used only when PS2_RX_FILTER_EN is defined).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk.
ps2_data  in  1  raw PS/2 data line, asynchronous to clk.
data  out  8  last valid received byte, LSB first on the wire; held until the next valid frame.
rdy  out  1  1-cycle pulse: `data` has just been updated with a valid byte.
err  out  1  1-cycle pulse: frame rejected (parity, start/stop bit, or timeout).
busy  out  1  high from start-bit acceptance until the frame completes or aborts.

Behaviour:
- Reset (rst=0, async): data=8'h00, rdy=0, err=0, busy=0, FSM=IDLE, shift register and counters cleared, synchronisers set to 1 (idle-high bus).
- Sync: each of `ps2_clk` and `ps2_data` passes through a 2-flop synchroniser.
- Edge detect: a falling edge is sync_clk_prev=1 and sync_clk=0. `ps2_data` is sampled from its synchroniser in the same cycle the edge is detected.
- FSM states and transitions:
  - IDLE: on a falling edge with sampled data=0 (start bit), go to DATA, set bit_cnt=0, busy=1. A falling edge with data=1 is ignored (stay in IDLE, no err).
  - DATA: on each falling edge, shift the sample into bit 7 and shift right (LSB arrives first), then increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on a falling edge, latch the parity bit and go to STOP.
  - STOP: on a falling edge, check the frame. If stop=1 and ^{shift,parity}==1 (odd parity), load data=shift and pulse rdy. Otherwise pulse err and leave data unchanged. Either way go to IDLE with busy=0.
- Output latency: rdy/err are asserted in the cycle after the stop-bit edge is detected, for exactly one cycle.
- Timeout:
  - A counter of width clog2(CLK_HZ/1000000*TIMEOUT_US+1) clears on every falling edge and increments every cycle while not in IDLE.
  - When it reaches CLK_HZ/1000000*TIMEOUT_US: pulse err, go to IDLE, busy=0.
  - The counter saturates and does not wrap.
- rdy and err are never high in the same cycle.
- Back-to-back frames: a start bit is accepted in the cycle after STOP completes; no dead time is required.
- Async reset mid-frame aborts the partial frame silently: no rdy, no err.
- There is no host-to-device (inhibit/transmit) support; this block never drives the bus.

Optional Feature:
PS2_RX_FILTER_EN:
- Defined: the filtered clock level changes only after FILTER_LEN consecutive clk samples of the synchronised `ps2_clk` agree on the new level. Edge detection uses the filtered level, and `ps2_data` is delayed by the same FILTER_LEN cycles so it stays aligned. This rejects glitches shorter than FILTER_LEN cycles. Added latency equals FILTER_LEN cycles.
- Not defined: edge detection uses the raw synchronised clock directly, with no filter logic and no extra latency.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one rdy pulse, data=8'h1C, err=0, busy returns to 0.
- Frames 0xF0 then 0x1C back-to-back with minimum idle between them -> two rdy pulses, data=8'hF0 then 8'h1C.
- Frame 0x1C with parity=1 -> err pulses once, no rdy, data keeps its prior value.
- Frame 0x12 with stop=0 -> err pulses, no rdy.
- Stall after the 4th data bit for >200 us (CLK_HZ=12 MHz, i.e. 2400 cycles) -> err pulses at cycle 2400, busy=0. A following valid 0x29 frame -> rdy with data=8'h29.
- Assert rst=0 after the 5th bit, release, then send 0x5A -> no err or rdy during reset; afterwards rdy with data=8'h5A. With PS2_RX_FILTER_EN, a 1-cycle `ps2_clk` glitch mid-frame -> no extra bit shifted, data still correct.
